// File: rtl/mem_access_if.sv
// RAM port of the memory-access stage: one registered request, completed by ram_ready.
interface mem_access_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_ready
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_ready
  );
endinterface

// File: rtl/mem_access.sv
// Pipeline MEM stage: stage-A register, one-request RAM FSM, load alignment/extension, WB register.
// Handshake: a request is presented while ram_en=1 and held stable; it completes on the
// first rising edge where ram_en=1 and ram_ready=1. Until then stall_req freezes upstream.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  mem_access_if.master bus,
  output logic        stall_req,
  output logic        mem_load_flag,
  output logic        wb_valid,
  output logic        reg_write_en_out,
  output logic        addr_err_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] result_out,
  output logic [31:0] current_pc_addr_out,
  output logic        dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;

  logic        a_valid_q, a_read_q, a_write_q, a_sext_q, a_rwe_q;
  logic [3:0]  a_sel_q;
  logic [31:0] a_result_q, a_pc_q;
  logic [4:0]  a_rwaddr_q;

  logic        ram_en_q, ram_en_d;
  logic [3:0]  ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;

  logic        wb_valid_q, wb_rwe_q, wb_err_q;
  logic        wb_valid_d, wb_rwe_d, wb_err_d;
  logic [4:0]  wb_rwaddr_q;
  logic [31:0] wb_result_q, wb_result_d, wb_pc_q;

  logic        in_misalign, mem_op_in, stall;
  logic        a_misalign, a_mem;
  logic [31:0] ld_shift, ld_mask, ld_data;

  assign in_misalign = ((mem_sel_in == 4'b1111) && (result_in[1:0] != 2'b00)) ||
                       ((mem_sel_in == 4'b0011) && result_in[0]);
  assign mem_op_in   = in_valid && (mem_read_flag_in || mem_write_flag_in) && !in_misalign;
  assign stall       = (state_q == ACCESS) && !bus.ram_ready;

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      state_d = mem_op_in ? ACCESS : IDLE;
    end
  end

  always_comb begin
    ram_en_d    = mem_op_in;
    ram_addr_d  = {result_in[31:2], 2'b00};
    ram_we_d    = 4'b0000;
    if (mem_op_in && mem_write_flag_in) begin
      ram_we_d = mem_sel_in << result_in[1:0];
    end
    ram_wdata_d = mem_write_data_in << {result_in[1:0], 3'b000};
  end

  assign a_misalign = ((a_sel_q == 4'b1111) && (a_result_q[1:0] != 2'b00)) ||
                      ((a_sel_q == 4'b0011) && a_result_q[0]);
  assign a_mem      = a_read_q || a_write_q;

  // Lane 0 of the shifted word holds the addressed byte/half; sel masks the width.
  always_comb begin
    ld_shift = bus.ram_read_data >> {a_result_q[1:0], 3'b000};
    ld_mask  = {{8{a_sel_q[3]}}, {8{a_sel_q[2]}}, {8{a_sel_q[1]}}, {8{a_sel_q[0]}}};
    ld_data  = ld_shift & ld_mask;
    if (a_sext_q && (a_sel_q == 4'b0001)) begin
      ld_data = {{24{ld_data[7]}}, ld_data[7:0]};
    end else if (a_sext_q && (a_sel_q == 4'b0011)) begin
      ld_data = {{16{ld_data[15]}}, ld_data[15:0]};
    end
  end

  always_comb begin
    wb_valid_d  = a_valid_q;
    wb_rwe_d    = a_valid_q && a_rwe_q && !a_write_q && !a_misalign;
    wb_err_d    = a_valid_q && a_mem && a_misalign;
    wb_result_d = (a_read_q && !a_misalign) ? ld_data : a_result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_valid_q   <= 1'b0;
      a_read_q    <= 1'b0;
      a_write_q   <= 1'b0;
      a_sext_q    <= 1'b0;
      a_rwe_q     <= 1'b0;
      a_sel_q     <= 4'b0000;
      a_result_q  <= 32'h0;
      a_pc_q      <= 32'h0;
      a_rwaddr_q  <= 5'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rwe_q    <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_rwaddr_q <= 5'd0;
      wb_result_q <= 32'h0;
      wb_pc_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        a_valid_q   <= in_valid;
        a_read_q    <= mem_read_flag_in;
        a_write_q   <= mem_write_flag_in;
        a_sext_q    <= mem_sign_ext_flag_in;
        a_rwe_q     <= reg_write_en_in;
        a_sel_q     <= mem_sel_in;
        a_result_q  <= result_in;
        a_pc_q      <= current_pc_addr_in;
        a_rwaddr_q  <= reg_write_addr_in;
        ram_en_q    <= ram_en_d;
        ram_we_q    <= ram_we_d;
        ram_addr_q  <= ram_addr_d;
        ram_wdata_q <= ram_wdata_d;
        wb_valid_q  <= wb_valid_d;
        wb_rwe_q    <= wb_rwe_d;
        wb_err_q    <= wb_err_d;
        wb_rwaddr_q <= a_rwaddr_q;
        wb_result_q <= wb_result_d;
        wb_pc_q     <= a_pc_q;
      end else begin
        wb_valid_q  <= 1'b0;
        wb_rwe_q    <= 1'b0;
        wb_err_q    <= 1'b0;
      end
    end
  end

  assign bus.ram_en         = ram_en_q;
  assign bus.ram_write_en   = ram_we_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_write_data = ram_wdata_q;

  assign stall_req           = stall;
  assign mem_load_flag       = a_valid_q && a_read_q;
  assign wb_valid            = wb_valid_q;
  assign reg_write_en_out    = wb_rwe_q;
  assign addr_err_out        = wb_err_q;
  assign reg_write_addr_out  = wb_rwaddr_q;
  assign result_out          = wb_result_q;
  assign current_pc_addr_out = wb_pc_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: issued instructions push their WB record into exp_q,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_mem_access;
  logic        clk, rst;
  logic        in_valid, rd, wr, sx, rwe;
  logic [3:0]  sel;
  logic [31:0] wdata, addr, pc;
  logic [4:0]  raddr;
  logic        stall_req, mem_load_flag, wb_valid, reg_write_en_out, addr_err_out, dbg_state;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] result_out, current_pc_addr_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [70:0] exp_q[$];

  mem_access_if bus ();

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .mem_read_flag_in(rd), .mem_write_flag_in(wr), .mem_sign_ext_flag_in(sx),
    .mem_sel_in(sel), .mem_write_data_in(wdata), .result_in(addr),
    .reg_write_en_in(rwe), .reg_write_addr_in(raddr), .current_pc_addr_in(pc),
    .bus(bus),
    .stall_req(stall_req), .mem_load_flag(mem_load_flag), .wb_valid(wb_valid),
    .reg_write_en_out(reg_write_en_out), .addr_err_out(addr_err_out),
    .reg_write_addr_out(reg_write_addr_out), .result_out(result_out),
    .current_pc_addr_out(current_pc_addr_out), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [70:0] pack(input logic [31:0] res, input logic we,
                                       input logic [4:0] ra, input logic err,
                                       input logic [31:0] p);
    return {res, we, ra, err, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic s, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] a, input logic we,
                       input logic [4:0] ra, input logic [31:0] p);
    in_valid = 1'b1; rd = r; wr = w; sx = s; sel = m;
    wdata = d; addr = a; rwe = we; raddr = ra; pc = p;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; rd = 1'b0; wr = 1'b0; sx = 1'b0; rwe = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_en"}, {31'd0, bus.ram_en}, 32'd0);
    chk({tag, "_ram_we"}, {28'd0, bus.ram_write_en}, 32'd0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
    chk({tag, "_ram_wdata"}, bus.ram_write_data, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_rwe"}, {31'd0, reg_write_en_out}, 32'd0);
    chk({tag, "_err"}, {31'd0, addr_err_out}, 32'd0);
    chk({tag, "_result"}, result_out, 32'd0);
    chk({tag, "_pc"}, current_pc_addr_out, 32'd0);
    chk({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    chk({tag, "_load_flag"}, {31'd0, mem_load_flag}, 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [70:0] got, e;
    if (!rst && wb_valid) begin
      n_tests++;
      got = pack(result_out, reg_write_en_out, reg_write_addr_out, addr_err_out,
                 current_pc_addr_out);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got %h expected nothing", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL wb_record: got res=%h we=%b ra=%0d err=%b pc=%h expected res=%h we=%b ra=%0d err=%b pc=%h",
                   got[70:39], got[38], got[37:33], got[32], got[31:0],
                   e[70:39], e[38], e[37:33], e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive_idle();
    sel = 4'b0000; wdata = 32'h0; addr = 32'h0; raddr = 5'd0; pc = 32'h0;
    bus.ram_ready = 1'b1;
    bus.ram_read_data = 32'h0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // ADDU: one-edge latency, no stall
    drive(1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h1234, 1'b1, 5'd5, 32'h1000);
    exp_q.push_back(pack(32'h1234, 1'b1, 5'd5, 1'b0, 32'h1000));
    tick(); drive_idle();
    at_neg(); chk("addu_stall", {31'd0, stall_req}, 32'd0);
    chk("addu_ram_en", {31'd0, bus.ram_en}, 32'd0);
    tick(); at_neg(); chk("addu_wb_valid", {31'd0, wb_valid}, 32'd1);
    tick();

    // LB signed at 0x103, ready already high
    bus.ram_ready = 1'b1; bus.ram_read_data = 32'h80FFFFFF;
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h103, 1'b1, 5'd6, 32'h1004);
    exp_q.push_back(pack(32'hFFFFFF80, 1'b1, 5'd6, 1'b0, 32'h1004));
    tick(); drive_idle();
    at_neg();
    chk("lb_ram_en", {31'd0, bus.ram_en}, 32'd1);
    chk("lb_ram_addr", bus.ram_addr, 32'h100);
    chk("lb_ram_we", {28'd0, bus.ram_write_en}, 32'd0);
    chk("lb_stall", {31'd0, stall_req}, 32'd0);
    chk("lb_load_flag", {31'd0, mem_load_flag}, 32'd1);
    tick(); at_neg();
    chk("lb_ram_en_drop", {31'd0, bus.ram_en}, 32'd0);
    chk("lb_stall2", {31'd0, stall_req}, 32'd0);
    tick();

    // SH at 0x22 with ready low for three cycles
    bus.ram_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000BEEF, 32'h22, 1'b1, 5'd7, 32'h1008);
    exp_q.push_back(pack(32'h22, 1'b0, 5'd7, 1'b0, 32'h1008));
    tick(); drive_idle();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("sh_stall", {31'd0, stall_req}, 32'd1);
      chk("sh_ram_en", {31'd0, bus.ram_en}, 32'd1);
      chk("sh_ram_addr", bus.ram_addr, 32'h20);
      chk("sh_ram_we", {28'd0, bus.ram_write_en}, 32'hC);
      chk("sh_ram_wdata", bus.ram_write_data, 32'hBEEF0000);
      if (i > 0) chk("sh_bubble", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    bus.ram_ready = 1'b1;
    at_neg();
    chk("sh_bubble3", {31'd0, wb_valid}, 32'd0);
    chk("sh_stall_end", {31'd0, stall_req}, 32'd0);
    tick(); at_neg();
    chk("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sh_ram_en_drop", {31'd0, bus.ram_en}, 32'd0);
    tick();

    // LW misaligned at 0x41
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h41, 1'b1, 5'd8, 32'h100C);
    exp_q.push_back(pack(32'h41, 1'b0, 5'd8, 1'b1, 32'h100C));
    tick(); drive_idle();
    at_neg();
    chk("mis_ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("mis_stall", {31'd0, stall_req}, 32'd0);
    chk("mis_load_flag", {31'd0, mem_load_flag}, 32'd1);
    tick(); at_neg();
    chk("mis_err", {31'd0, addr_err_out}, 32'd1);
    tick();

    // SW then LW back-to-back
    bus.ram_ready = 1'b1; bus.ram_read_data = 32'h11223344;
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'hCAFEBABE, 32'h80, 1'b0, 5'd9, 32'h1010);
    exp_q.push_back(pack(32'h80, 1'b0, 5'd9, 1'b0, 32'h1010));
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h84, 1'b1, 5'd10, 32'h1014);
    exp_q.push_back(pack(32'h11223344, 1'b1, 5'd10, 1'b0, 32'h1014));
    at_neg();
    chk("b2b_sw_en", {31'd0, bus.ram_en}, 32'd1);
    chk("b2b_sw_we", {28'd0, bus.ram_write_en}, 32'hF);
    chk("b2b_sw_wdata", bus.ram_write_data, 32'hCAFEBABE);
    chk("b2b_sw_addr", bus.ram_addr, 32'h80);
    tick(); drive_idle();
    at_neg();
    chk("b2b_lw_en", {31'd0, bus.ram_en}, 32'd1);
    chk("b2b_lw_we", {28'd0, bus.ram_write_en}, 32'd0);
    chk("b2b_lw_addr", bus.ram_addr, 32'h84);
    chk("b2b_wb1", {31'd0, wb_valid}, 32'd1);
    tick(); at_neg();
    chk("b2b_en_drop", {31'd0, bus.ram_en}, 32'd0);
    chk("b2b_wb2", {31'd0, wb_valid}, 32'd1);
    tick();

    // LH unsigned upper half, LH signed lower half
    bus.ram_read_data = 32'hABCD9876;
    drive(1'b1, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h206, 1'b1, 5'd11, 32'h1018);
    exp_q.push_back(pack(32'h0000ABCD, 1'b1, 5'd11, 1'b0, 32'h1018));
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h200, 1'b1, 5'd12, 32'h101C);
    exp_q.push_back(pack(32'hFFFF9876, 1'b1, 5'd12, 1'b0, 32'h101C));
    tick(); drive_idle();
    tick(); at_neg(); tick();

    // reset in the middle of an ACCESS
    bus.ram_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h300, 1'b1, 5'd13, 32'h1020);
    tick(); drive_idle();
    at_neg();
    chk("rstacc_stall", {31'd0, stall_req}, 32'd1);
    chk("rstacc_state", {31'd0, dbg_state}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    bus.ram_ready = 1'b1;
    #1 rst = 1'b0;
    tick(); at_neg();
    chk("postrst_stall", {31'd0, stall_req}, 32'd0);
    chk("postrst_ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("postrst_wb", {31'd0, wb_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h5678, 1'b1, 5'd14, 32'h1024);
    exp_q.push_back(pack(32'h5678, 1'b1, 5'd14, 1'b0, 32'h1024));
    tick(); drive_idle();
    tick(); at_neg();
    chk("postrst_wb_valid", {31'd0, wb_valid}, 32'd1);
    repeat (3) tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
